// File: rtl/cva6_ptw_sv32_lite.sv
// -----------------------------------------------------------------------------
// cva6_ptw_sv32_lite
//
// Sv32 page-table walker that handles one TLB miss at a time. It accepts a
// miss (vaddr, asid) and performs one or two PTE reads over a req/gnt/rvalid
// memory port. It then produces either a one-cycle packed TLB update word or a
// one-cycle page-fault pulse.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              abort the walk in progress (sfence.vma)
//   satp_ppn_i           root page-table PPN, sampled when a miss is accepted
//   miss_valid_i/ready_o miss handshake; ready only in IDLE without a flush
//   miss_vaddr_i/asid_i  faulting virtual address and its ASID
//   mem_req_o/gnt_i      PTE read request; address held stable until granted
//   mem_addr_o           34-bit physical PTE address
//   mem_rvalid_i/rdata_i PTE read response
//   update_o             {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}
//   fault_o              page-fault pulse; fault_vaddr_o holds until next fault
//   busy_o               walker is not idle
// -----------------------------------------------------------------------------
module cva6_ptw_sv32_lite #(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PPN_WIDTH  = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [PPN_WIDTH-1:0]  satp_ppn_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [33:0]           mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  fault_o,
    output logic [31:0]           fault_vaddr_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReqL1,
        StWaitL1,
        StReqL0,
        StWaitL0,
        StUpdate,
        StFault,
        StDrain
    } state_e;

    state_e                 state_q;
    logic [31:0]            vaddr_q;
    logic [ASID_WIDTH-1:0]  asid_q;
    logic                   mem_req_q;
    logic [33:0]            mem_addr_q;
    logic [62:0]            update_q;
    logic                   fault_q;
    logic [31:0]            fault_vaddr_q;

    // PTE decode of the word currently on the response bus.
    logic       pte_invalid;
    logic       pte_leaf;
    logic       pte_misaligned;
    logic [8:0] asid_ext;

    always_comb begin
        pte_invalid    = !mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2]);
        pte_leaf       = mem_rdata_i[1] || mem_rdata_i[3];
        // A 4 MiB leaf must have a zero low PPN field.
        pte_misaligned = (mem_rdata_i[19:10] != 10'd0);
    end

    always_comb begin
        asid_ext                   = '0;
        asid_ext[ASID_WIDTH-1:0]   = asid_q;
    end

    assign miss_ready_o  = (state_q == StIdle) && !flush_i;
    assign busy_o        = (state_q != StIdle);
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign update_o      = update_q;
    assign fault_o       = fault_q;
    assign fault_vaddr_o = fault_vaddr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            vaddr_q       <= '0;
            asid_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            update_q      <= '0;
            fault_q       <= 1'b0;
            fault_vaddr_q <= '0;
        end else begin
            // Update and fault are single-cycle pulses.
            update_q <= '0;
            fault_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (miss_valid_i && miss_ready_o) begin
                        vaddr_q    <= miss_vaddr_i;
                        asid_q     <= miss_asid_i;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
                        state_q    <= StReqL1;
                    end
                end

                StReqL1, StReqL0: begin
                    if (mem_gnt_i) begin
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                        // A granted read must still have its response consumed.
                        if (flush_i) begin
                            state_q <= StDrain;
                        end else if (state_q == StReqL1) begin
                            state_q <= StWaitL1;
                        end else begin
                            state_q <= StWaitL0;
                        end
                    end else if (flush_i) begin
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= StIdle;
                    end
                end

                StWaitL1: begin
                    if (flush_i) begin
                        // Response arriving with the flush is already consumed.
                        state_q <= mem_rvalid_i ? StIdle : StDrain;
                    end else if (mem_rvalid_i) begin
                        if (pte_invalid || (pte_leaf && pte_misaligned)) begin
                            fault_q       <= 1'b1;
                            fault_vaddr_q <= vaddr_q;
                            state_q       <= StFault;
                        end else if (pte_leaf) begin
                            update_q <= {1'b1, 1'b1, vaddr_q[31:12], asid_ext, mem_rdata_i};
                            state_q  <= StUpdate;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {mem_rdata_i[31:10], vaddr_q[21:12], 2'b00};
                            state_q    <= StReqL0;
                        end
                    end
                end

                StWaitL0: begin
                    if (flush_i) begin
                        state_q <= mem_rvalid_i ? StIdle : StDrain;
                    end else if (mem_rvalid_i) begin
                        if (pte_invalid || !pte_leaf) begin
                            fault_q       <= 1'b1;
                            fault_vaddr_q <= vaddr_q;
                            state_q       <= StFault;
                        end else begin
                            update_q <= {1'b1, 1'b0, vaddr_q[31:12], asid_ext, mem_rdata_i};
                            state_q  <= StUpdate;
                        end
                    end
                end

                StUpdate, StFault: begin
                    state_q <= StIdle;
                end

                StDrain: begin
                    if (mem_rvalid_i) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // An ungranted request keeps its address until granted or flushed.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i && !flush_i) |=> (mem_req_o && $stable(mem_addr_o)));

    // Update and fault never issue together.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(update_o[62] && fault_o));

endmodule
